// File: rtl/sram_pkg.sv
// Shared types and sizing for the 2048x16 SRAM controller.
package sram_pkg;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 2048;
    localparam int BURST_LEN = 4;
    localparam int BEAT_W    = $clog2(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sram_bus_drv.sv
// Tristate driver for the shared SRAM data bus; releases the bus when oe is low.
module sram_bus_drv
    import sram_pkg::*;
(
    input  logic              oe,
    input  logic [DATA_W-1:0] dout,
    inout  wire  [DATA_W-1:0] bus
);

    assign bus = oe ? dout : {DATA_W{1'bz}};

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM controller: one-beat read/write, optional 4-beat read burst
// when SRAM_CTRL_BURST_EN is defined.
module sram_ctrl
    import sram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              burst,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_t              state_reg, state_next;
    logic                we_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                rvalid_reg;
    logic                last_beat;

`ifdef SRAM_CTRL_BURST_EN
    logic                burst_reg;
    logic [BEAT_W-1:0]   beat_reg;

    // Writes never burst, so the flag is qualified with a read at capture time.
    assign last_beat = !burst_reg || (beat_reg == BEAT_W'(BURST_LEN - 1));
`else
    logic                unused_burst;

    assign unused_burst = burst;
    assign last_beat    = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = ACCESS;
            ACCESS:  if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            mem_addr_reg <= '0;
            rdata_reg    <= '0;
            rvalid_reg   <= 1'b0;
`ifdef SRAM_CTRL_BURST_EN
            burst_reg    <= 1'b0;
            beat_reg     <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            rvalid_reg <= 1'b0;
            if (state_reg == IDLE && req) begin
                we_reg       <= we;
                wdata_reg    <= wdata;
                mem_addr_reg <= addr;
`ifdef SRAM_CTRL_BURST_EN
                burst_reg    <= burst && !we;
                beat_reg     <= '0;
`endif
            end
            if (state_reg == ACCESS) begin
                if (!we_reg) begin
                    rdata_reg  <= mem_data;
                    rvalid_reg <= 1'b1;
                end
`ifdef SRAM_CTRL_BURST_EN
                // Step to the next word; the 11-bit add wraps 2047 to 0.
                if (!last_beat) begin
                    mem_addr_reg <= mem_addr_reg + ADDR_W'(1);
                    beat_reg     <= beat_reg + BEAT_W'(1);
                end
`endif
            end
        end
    end

    assign mem_write = (state_reg == ACCESS) && we_reg;
    assign mem_addr  = mem_addr_reg;
    assign rdata     = rdata_reg;
    assign rvalid    = rvalid_reg;
    assign ack       = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);

    sram_bus_drv u_bus_drv (
        .oe   (mem_write),
        .dout (wdata_reg),
        .bus  (mem_data)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural 2048x16 SRAM on the bus.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [10:0] addr;
    logic [15:0] wdata;
    logic        burst;
    logic [15:0] rdata;
    logic        rvalid;
    logic        ack;
    logic        busy;
    logic [10:0] mem_addr;
    logic        mem_write;
    wire  [15:0] mem_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct { int c; logic [15:0] d; } rd_exp_t;
    typedef struct { int c; logic [10:0] a; logic [15:0] d; } wr_exp_t;

    int      ack_q[$];
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    logic [15:0] sram [0:2047];
    logic [15:0] sram_q = 16'hFFFF;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .burst     (burst),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .ack       (ack),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .mem_data  (mem_data)
    );

    // SRAM model: acts on the negedge, drives the bus whenever not written.
    initial for (int i = 0; i < 2048; i++) sram[i] = 16'hFFFF;
    assign mem_data = mem_write ? 16'hzzzz : sram_q;
    always @(negedge clk) begin
        if (mem_write) sram[mem_addr] <= mem_data;
        else           sram_q <= sram[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents ack, rvalid or a write.
    always @(negedge clk) begin
        if (!reset) begin
            if (ack) begin
                if (ack_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
                else chk("ack_cycle", cyc, ack_q.pop_front());
            end
            if (rvalid) begin
                if (rd_q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    chk("rvalid_cycle", cyc, e.c);
                    chk("rdata", {16'd0, rdata}, {16'd0, e.d});
                end
            end
            if (mem_write) begin
                if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    wr_exp_t w;
                    w = wr_q.pop_front();
                    chk("write_cycle", cyc, w.c);
                    chk("write_addr", {21'd0, mem_addr}, {21'd0, w.a});
                    chk("write_data", {16'd0, mem_data}, {16'd0, w.d});
                end
            end else begin
                chk("bus_released", {16'd0, mem_data}, {16'd0, sram_q});
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Called just after a negedge; leaves the bench just after a negedge with the DUT idle.
    task automatic issue(input logic w, input logic [10:0] a, input logic [15:0] d,
                         input logic b, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
        int beats;
        int acc;
        logic [15:0] ev [4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        beats = 1;
`ifdef SRAM_CTRL_BURST_EN
        if (b && !w) beats = 4;
`endif
        req = 1'b1; we = w; addr = a; wdata = d; burst = b;
        @(posedge clk); #1;
        acc = cyc;
        ack_q.push_back(acc + beats);
        if (w) wr_q.push_back('{c: acc, a: a, d: d});
        else for (int k = 0; k < beats; k++) rd_q.push_back('{c: acc + k + 1, d: ev[k]});
        $display("txn: %s addr=%h wdata=%h burst=%0d beats=%0d accepted at cycle %0d",
                 w ? "write" : "read ", a, d, b, beats, acc);
        @(negedge clk);
        req = 1'b0;
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; burst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata",     {16'd0, rdata}, 32'd0);
        chk("rst_rvalid",    {31'd0, rvalid}, 32'd0);
        chk("rst_ack",       {31'd0, ack}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_mem_addr",  {21'd0, mem_addr}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Write then read back, unwritten read, second data pattern.
        issue(1'b1, 11'h005, 16'hA5A5, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b0, 11'h005, 16'h0000, 1'b0, 16'hA5A5, 16'h0, 16'h0, 16'h0);
        issue(1'b0, 11'h7FF, 16'h0000, 1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0);
        issue(1'b1, 11'h123, 16'h0F0F, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b1, 11'h000, 16'h5A5A, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b0, 11'h123, 16'h0000, 1'b0, 16'h0F0F, 16'h0, 16'h0, 16'h0);
        issue(1'b0, 11'h000, 16'h0000, 1'b0, 16'h5A5A, 16'h0, 16'h0, 16'h0);
        chk("rdata_hold", {16'd0, rdata}, 32'h0000_5A5A);

        // req held through ACCESS and DONE with a different address/op: ignored.
        req = 1'b1; we = 1'b0; addr = 11'h005; burst = 1'b0;
        @(posedge clk); #1;
        acc = cyc;
        ack_q.push_back(acc + 1);
        rd_q.push_back('{c: acc + 1, d: 16'hA5A5});
        $display("txn: read  addr=005 with req held (busy ignore) accepted at cycle %0d", acc);
        @(negedge clk);
        addr = 11'h123; we = 1'b1; wdata = 16'hDEAD;
        @(negedge clk);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        wait_idle();

        // Reset during the ACCESS of a write: aborted, no ack, bus released at once.
        req = 1'b1; we = 1'b1; addr = 11'h010; wdata = 16'hBEEF;
        @(posedge clk); #1;
        $display("txn: write addr=010 wdata=BEEF aborted by reset at cycle %0d", cyc);
        reset = 1'b1;
        #1;
        chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
        chk("abort_busy",      {31'd0, busy}, 32'd0);
        chk("abort_ack",       {31'd0, ack}, 32'd0);
        chk("abort_mem_addr",  {21'd0, mem_addr}, 32'd0);
        chk("abort_rdata",     {16'd0, rdata}, 32'd0);
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b0, 11'h010, 16'h0000, 1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0);

`ifdef SRAM_CTRL_BURST_EN
        issue(1'b1, 11'h7FE, 16'h1111, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b1, 11'h7FF, 16'h2222, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b1, 11'h000, 16'h3333, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b1, 11'h001, 16'h4444, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b0, 11'h7FE, 16'h0000, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        issue(1'b1, 11'h002, 16'h7777, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b0, 11'h002, 16'h0000, 1'b0, 16'h7777, 16'h0, 16'h0, 16'h0);
`else
        issue(1'b0, 11'h005, 16'h0000, 1'b1, 16'hA5A5, 16'h0, 16'h0, 16'h0);
        issue(1'b1, 11'h006, 16'h7777, 1'b1, 16'h0, 16'h0, 16'h0, 16'h0);
        issue(1'b0, 11'h006, 16'h0000, 1'b0, 16'h7777, 16'h0, 16'h0, 16'h0);
`endif

        repeat (4) @(negedge clk);
        chk("ack_q_drained",   ack_q.size(), 32'd0);
        chk("rd_q_drained",    rd_q.size(), 32'd0);
        chk("wr_q_drained",    wr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
